calc_key_sequencer: RTL and testbench
=====================================

# calc_key_sequencer

Parametrised keypad-to-datapath sequencer for the ARM calculator. It turns level key strobes (digit, operator, equals, clear) into single-cycle control pulses for the entry register, the operand latch and the ALU/result path. It adds several behaviours: internal edge detection, a digit-count limit, operator replacement, optional chained operations and a clear key. It sits between the keypad decoder and the calculator datapath.

## Interface
- MAX_DIGITS, 4: maximum digits accepted per operand entry.
- CNT_W, 3: width of digit_count; must satisfy 2^CNT_W > MAX_DIGITS.
- OP_W, 2: operator code width.
- CHAIN_EN, 1: 1 lets an operator key in ENTRY_B evaluate and continue; 0 ignores it.

- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- rec_num  in  1  digit key level (high while held).
- rec_op  in  1  operator key level.
- rec_eq  in  1  equals key level.
- rec_clr  in  1  clear key level.
- op_code  in  OP_W  operator code; valid whenever rec_op is high.
- shift_digit  out  1  pulse: shift current digit into entry register.
- clear_entry  out  1  pulse: zero the entry register.
- guarde_num  out  1  pulse: latch entry register as operand A.
- lea_result  out  1  pulse: ALU computes A op entry and writes accumulator/display.
- op_latched  out  OP_W  registered pending operator.
- show_result  out  1  level: display shows accumulator.
- digit_count  out  CNT_W  digits accepted in current entry.
- entry_full  out  1  digit_count == MAX_DIGITS (decoded from the register).
- state_o  out  2  current state: IDLE=0, ENTRY_A=1, ENTRY_B=2, RESULT=3.

## Operation
- Edge detect: the previous-level register p_x holds each rec_x. event_x = rec_x & ~p_x. A held key produces exactly one event.
- Priority when events coincide: clr > eq > op > num. Only the highest-priority event acts; the others are discarded.
- clr event in any state: clear_entry=1, digit_count=0, op_latched=0, show_result=0, go to IDLE.
- Digit acceptance in any state: a num event asserts shift_digit and increments digit_count only if digit_count < MAX_DIGITS. Otherwise it is ignored with no pulse, and entry_full stays 1.
- IDLE:
  - num: accepted as first digit, go to ENTRY_A.
  - op, eq: ignored.
- ENTRY_A:
  - num: accepted.
  - op: guarde_num=1, clear_entry=1, op_latched<=op_code, digit_count<=0, go to ENTRY_B.
  - eq: ignored.
- ENTRY_B:
  - num: accepted.
  - op with digit_count==0: op_latched<=op_code only (operator replacement), stay.
  - op with digit_count>0 and CHAIN_EN=1: lea_result=1, clear_entry=1, op_latched<=op_code, digit_count<=0, stay. The accumulator becomes operand A.
  - op with digit_count>0 and CHAIN_EN=0: ignored.
  - eq with digit_count>0: lea_result=1, go to RESULT.
  - eq with digit_count==0: ignored.
- RESULT: show_result=1.
  - num: clear_entry=1 and shift_digit=1 in the same cycle, digit_count<=1, show_result<=0, go to ENTRY_A.
  - op: op_latched<=op_code, clear_entry=1, digit_count<=0, show_result<=0, go to ENTRY_B. No guarde_num; the accumulator already holds A.
  - eq: ignored.
- When both are asserted, the datapath applies clear_entry before shift_digit.

## Timing
- All outputs are registered.
- A key sampled high at edge k while p_x=0 causes its pulse output(s) to be high for exactly the cycle after edge k. State and counters update at edge k.
- Pulse outputs are never high for two consecutive cycles from one key press.
- Reset (rst high at an edge):
  - state=IDLE.
  - All pulses=0, op_latched=0, show_result=0, digit_count=0.
  - p_x<=rec_x, so a key held through reset release generates no event.
- Reset mid-operation discards pending op and count, with no pulses in the following cycle.
- Back-to-back presses need rec_x low for at least one sampled edge between them.

## Test plan
- Reset, press digits 1,2 then op=2'b01, digits 3, eq:
  - shift_digit×2, then guarde_num+clear_entry with op_latched=01.
  - Then shift_digit×1, then lea_result; state_o=3, show_result=1.
- MAX_DIGITS=4, press digit six times in ENTRY_A -> four shift_digit pulses, digit_count=4, entry_full=1, no further pulses.
- In ENTRY_B with digit_count=0, op=10 then op=11 -> op_latched=11, no lea_result, no guarde_num.
- CHAIN_EN=1 sequence 5,+,3,- :
  - lea_result on the second op, op_latched=new code, digit_count=0, state stays 2.
  - With CHAIN_EN=0 the same second op produces no pulse.
- Hold rec_op high 10 cycles in ENTRY_A -> exactly one guarde_num. rec_op and rec_clr rising together -> clear only, state_o=0.
- Assert rst in ENTRY_B with digit_count=3 -> next cycle all outputs 0, state_o=0. A key held through reset produces no event until released and re-pressed.

Source files
------------

// File: rtl/calc_key_sequencer.sv
// Keypad-to-datapath sequencer for the calculator: edge-detects level key strobes
// and issues single-cycle control pulses for the entry register, operand latch and ALU.
module calc_key_sequencer #(
  parameter int MAX_DIGITS = 4,
  parameter int CNT_W      = 3,
  parameter int OP_W       = 2,
  parameter int CHAIN_EN   = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rec_num,
  input  logic            rec_op,
  input  logic            rec_eq,
  input  logic            rec_clr,
  input  logic [OP_W-1:0] op_code,
  output logic            shift_digit,
  output logic            clear_entry,
  output logic            guarde_num,
  output logic            lea_result,
  output logic [OP_W-1:0] op_latched,
  output logic            show_result,
  output logic [CNT_W-1:0] digit_count,
  output logic            entry_full,
  output logic [1:0]      state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ENTRY_A = 2'd1,
    ENTRY_B = 2'd2,
    RESULT  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_DIGITS);

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OP_W-1:0] op_q, op_d;
  logic            show_q, show_d;
  logic            shift_q, shift_d;
  logic            clear_q, clear_d;
  logic            guarde_q, guarde_d;
  logic            lea_q, lea_d;
  logic            p_num_q, p_op_q, p_eq_q, p_clr_q;

  logic ev_num, ev_op, ev_eq, ev_clr;
  logic can_shift;

  assign ev_num    = rec_num & ~p_num_q;
  assign ev_op     = rec_op  & ~p_op_q;
  assign ev_eq     = rec_eq  & ~p_eq_q;
  assign ev_clr    = rec_clr & ~p_clr_q;
  assign can_shift = (cnt_q < MAX_C);

  // Only the highest-priority event (clr > eq > op > num) acts in a given cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    show_d   = show_q;
    shift_d  = 1'b0;
    clear_d  = 1'b0;
    guarde_d = 1'b0;
    lea_d    = 1'b0;

    if (ev_clr) begin
      clear_d = 1'b1;
      cnt_d   = '0;
      op_d    = '0;
      show_d  = 1'b0;
      state_d = IDLE;
    end else if (ev_eq) begin
      if (state_q == ENTRY_B && cnt_q != '0) begin
        lea_d   = 1'b1;
        show_d  = 1'b1;
        state_d = RESULT;
      end
    end else if (ev_op) begin
      case (state_q)
        ENTRY_A: begin
          guarde_d = 1'b1;
          clear_d  = 1'b1;
          op_d     = op_code;
          cnt_d    = '0;
          state_d  = ENTRY_B;
        end
        ENTRY_B: begin
          if (cnt_q == '0) begin
            op_d = op_code;
          end else if (CHAIN_EN != 0) begin
            lea_d   = 1'b1;
            clear_d = 1'b1;
            op_d    = op_code;
            cnt_d   = '0;
          end
        end
        RESULT: begin
          // The accumulator already holds operand A, so no guarde_num here.
          clear_d = 1'b1;
          op_d    = op_code;
          cnt_d   = '0;
          show_d  = 1'b0;
          state_d = ENTRY_B;
        end
        default: ;
      endcase
    end else if (ev_num) begin
      if (state_q == RESULT) begin
        clear_d = 1'b1;
        shift_d = 1'b1;
        cnt_d   = CNT_W'(1);
        show_d  = 1'b0;
        state_d = ENTRY_A;
      end else if (can_shift) begin
        shift_d = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (state_q == IDLE) state_d = ENTRY_A;
      end
    end
  end

  // Key levels are captured even in reset so a key held through release gives no event.
  always_ff @(posedge clk) begin
    p_num_q <= rec_num;
    p_op_q  <= rec_op;
    p_eq_q  <= rec_eq;
    p_clr_q <= rec_clr;
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      show_q   <= 1'b0;
      shift_q  <= 1'b0;
      clear_q  <= 1'b0;
      guarde_q <= 1'b0;
      lea_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      show_q   <= show_d;
      shift_q  <= shift_d;
      clear_q  <= clear_d;
      guarde_q <= guarde_d;
      lea_q    <= lea_d;
    end
  end

  assign shift_digit = shift_q;
  assign clear_entry = clear_q;
  assign guarde_num  = guarde_q;
  assign lea_result  = lea_q;
  assign op_latched  = op_q;
  assign show_result = show_q;
  assign digit_count = cnt_q;
  assign entry_full  = (cnt_q == MAX_C);
  assign state_o     = state_q;

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Scoreboard bench for calc_key_sequencer: two instances (chaining on/off) share stimulus
// and are checked every cycle against a behavioural model of the key rules.
module tb_calc_key_sequencer;

  localparam int MAX_DIGITS = 4;
  localparam int K_NUM = 0, K_OP = 1, K_EQ = 2, K_CLR = 3;

  // Packed view: {shift, clear, guarde, lea, op[1:0], show, count[2:0], full, state[1:0]}
  typedef logic [12:0] ovec_t;

  typedef struct {
    int mode;
    int cnt;
    int op;
    bit show;
  } mstate_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rec_num, rec_op, rec_eq, rec_clr;
  logic [1:0] op_code;

  logic       sh0, cl0, gn0, lr0, sr0, ef0;
  logic [1:0] ol0, st0;
  logic [2:0] dc0;
  logic       sh1, cl1, gn1, lr1, sr1, ef1;
  logic [1:0] ol1, st1;
  logic [2:0] dc1;

  ovec_t   exp_q0[$];
  ovec_t   exp_q1[$];
  mstate_t ms[2];
  bit      p_num, p_op, p_eq, p_clr;
  int      checks = 0;
  int      errors = 0;

  always #5 clk = ~clk;

  calc_key_sequencer #(.MAX_DIGITS(4), .CNT_W(3), .OP_W(2), .CHAIN_EN(1)) dut_chain (
    .clk(clk), .rst(rst), .rec_num(rec_num), .rec_op(rec_op), .rec_eq(rec_eq),
    .rec_clr(rec_clr), .op_code(op_code), .shift_digit(sh0), .clear_entry(cl0),
    .guarde_num(gn0), .lea_result(lr0), .op_latched(ol0), .show_result(sr0),
    .digit_count(dc0), .entry_full(ef0), .state_o(st0)
  );

  calc_key_sequencer #(.MAX_DIGITS(4), .CNT_W(3), .OP_W(2), .CHAIN_EN(0)) dut_plain (
    .clk(clk), .rst(rst), .rec_num(rec_num), .rec_op(rec_op), .rec_eq(rec_eq),
    .rec_clr(rec_clr), .op_code(op_code), .shift_digit(sh1), .clear_entry(cl1),
    .guarde_num(gn1), .lea_result(lr1), .op_latched(ol1), .show_result(sr1),
    .digit_count(dc1), .entry_full(ef1), .state_o(st1)
  );

  // Reference model: applies one sampled edge of key levels to calculator i and returns
  // the outputs expected during the following cycle.
  task automatic modelStep(input int i, input bit chain, input bit r, input bit n,
                           input bit o, input bit e, input bit c, input int code,
                           output ovec_t res);
    bit sh = 0, cl = 0, gn = 0, lr = 0;
    bit en = n && !p_num;
    bit eo = o && !p_op;
    bit ee = e && !p_eq;
    bit ec = c && !p_clr;
    if (r) begin
      ms[i].mode = 0; ms[i].cnt = 0; ms[i].op = 0; ms[i].show = 0;
    end else if (ec) begin
      cl = 1; ms[i].cnt = 0; ms[i].op = 0; ms[i].show = 0; ms[i].mode = 0;
    end else if (ee) begin
      if (ms[i].mode == 2 && ms[i].cnt > 0) begin
        lr = 1; ms[i].mode = 3; ms[i].show = 1;
      end
    end else if (eo) begin
      if (ms[i].mode == 1) begin
        gn = 1; cl = 1; ms[i].op = code; ms[i].cnt = 0; ms[i].mode = 2;
      end else if (ms[i].mode == 2) begin
        if (ms[i].cnt == 0) ms[i].op = code;
        else if (chain) begin
          lr = 1; cl = 1; ms[i].op = code; ms[i].cnt = 0;
        end
      end else if (ms[i].mode == 3) begin
        cl = 1; ms[i].op = code; ms[i].cnt = 0; ms[i].show = 0; ms[i].mode = 2;
      end
    end else if (en) begin
      if (ms[i].mode == 3) begin
        cl = 1; sh = 1; ms[i].cnt = 1; ms[i].show = 0; ms[i].mode = 1;
      end else if (ms[i].cnt < MAX_DIGITS) begin
        sh = 1; ms[i].cnt++;
        if (ms[i].mode == 0) ms[i].mode = 1;
      end
    end
    res = {sh, cl, gn, lr, 2'(ms[i].op), ms[i].show, 3'(ms[i].cnt),
           (ms[i].cnt == MAX_DIGITS), 2'(ms[i].mode)};
  endtask

  task automatic applyStimulus(input bit r, input bit n, input bit o, input bit e,
                               input bit c, input int code);
    ovec_t e0, e1;
    @(negedge clk);
    rst = r; rec_num = n; rec_op = o; rec_eq = e; rec_clr = c; op_code = 2'(code);
    modelStep(0, 1'b1, r, n, o, e, c, code, e0);
    modelStep(1, 1'b0, r, n, o, e, c, code, e1);
    p_num = n; p_op = o; p_eq = e; p_clr = c;
    exp_q0.push_back(e0);
    exp_q1.push_back(e1);
  endtask

  task automatic pressKey(input int key, input int code);
    applyStimulus(1'b0, key == K_NUM, key == K_OP, key == K_EQ, key == K_CLR, code);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, code);
  endtask

  task automatic checkOutput(input int idx, input ovec_t got);
    ovec_t want;
    want = (idx == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL outputs dut%0d t=%0t: got %b, expected %b", idx, $time, got, want);
    end
  endtask

  // Monitor: compares each instance once per cycle, just after the active edge.
  always @(posedge clk) begin
    #1;
    if (exp_q0.size() > 0) checkOutput(0, {sh0, cl0, gn0, lr0, ol0, sr0, dc0, ef0, st0});
    if (exp_q1.size() > 0) checkOutput(1, {sh1, cl1, gn1, lr1, ol1, sr1, dc1, ef1, st1});
  end

  initial begin
    rst = 1'b1; rec_num = 0; rec_op = 0; rec_eq = 0; rec_clr = 0; op_code = 0;
    p_num = 0; p_op = 0; p_eq = 0; p_clr = 0;
    for (int i = 0; i < 2; i++) ms[i] = '{0, 0, 0, 0};

    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    $display("[TB] basic 12 op 3 =");
    pressKey(K_NUM, 0); pressKey(K_NUM, 0); pressKey(K_OP, 1);
    pressKey(K_NUM, 0); pressKey(K_EQ, 0);

    $display("[TB] digit limit");
    pressKey(K_CLR, 0);
    for (int i = 0; i < 6; i++) pressKey(K_NUM, 0);

    $display("[TB] operator replacement and chaining");
    pressKey(K_OP, 2); pressKey(K_OP, 3);
    pressKey(K_NUM, 0); pressKey(K_OP, 1);
    pressKey(K_NUM, 0); pressKey(K_EQ, 0); pressKey(K_NUM, 0); pressKey(K_OP, 2);

    $display("[TB] held operator and coincident clear");
    pressKey(K_CLR, 0); pressKey(K_NUM, 0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 1, 0, 0, 3);
    applyStimulus(0, 0, 0, 0, 0, 0);
    pressKey(K_NUM, 0);
    applyStimulus(0, 0, 1, 0, 1, 2);
    applyStimulus(0, 0, 0, 0, 0, 0);

    $display("[TB] reset in ENTRY_B with held key");
    pressKey(K_NUM, 0); pressKey(K_OP, 1);
    for (int i = 0; i < 3; i++) pressKey(K_NUM, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    pressKey(K_NUM, 0);

    $display("[TB] random key traffic");
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 199) == 0,
                    $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 20,
                    $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 3,
                    int'($urandom_range(0, 3)));
    end

    applyStimulus(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d/%0d entries left, required 0/0", exp_q0.size(), exp_q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
